// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope for one voice: trigger/gate driven state machine whose
// level steps once per sample_tick toward full scale, the sustain target, or zero.
module adsr_envelope #(
    parameter int ENV_W  = 16,
    parameter int RATE_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              trigger,
    input  logic              gate,
    input  logic              sample_tick,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [ENV_W-1:0]  sustain_level,
    input  logic [RATE_W-1:0] release_rate,
    output logic [ENV_W-1:0]  env_level,
    output logic              env_active,
    output logic              env_done,
    output logic [2:0]        env_state
);

    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    localparam int PAD = ENV_W + 1 - RATE_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ENV_W-1:0]  level_nxt;
    logic              done_nxt;

    // All arithmetic carries one extra bit so overflow/underflow is visible.
    logic [ENV_W:0]        att_ext, dec_ext, rel_ext;
    logic [ENV_W:0]        att_sum;
    logic signed [ENV_W:0] dec_diff, rel_diff;

    assign att_ext  = {{PAD{1'b0}}, attack_rate};
    assign dec_ext  = {{PAD{1'b0}}, decay_rate};
    assign rel_ext  = {{PAD{1'b0}}, release_rate};
    assign att_sum  = {1'b0, env_level} + att_ext;
    assign dec_diff = $signed({1'b0, env_level}) - $signed(dec_ext);
    assign rel_diff = $signed({1'b0, env_level}) - $signed(rel_ext);

    always_comb begin
        state_nxt = state;
        level_nxt = env_level;
        done_nxt  = 1'b0;
        if (trigger) begin
            // Level deliberately kept so a retrigger ramps up from where it is.
            state_nxt = ATTACK;
        end else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_nxt = RELEASE;
        end else begin
            case (state)
                IDLE: level_nxt = '0;
                ATTACK: if (sample_tick) begin
                    if (att_sum >= {1'b0, ENV_MAX} || attack_rate == '0) begin
                        level_nxt = ENV_MAX;
                        state_nxt = DECAY;
                    end else begin
                        level_nxt = att_sum[ENV_W-1:0];
                    end
                end
                DECAY: if (sample_tick) begin
                    if (dec_diff <= $signed({1'b0, sustain_level}) || decay_rate == '0) begin
                        level_nxt = sustain_level;
                        state_nxt = SUSTAIN;
                    end else begin
                        level_nxt = dec_diff[ENV_W-1:0];
                    end
                end
                SUSTAIN: if (sample_tick) level_nxt = sustain_level;
                RELEASE: if (sample_tick) begin
                    if (rel_diff[ENV_W] || rel_diff == '0 || release_rate == '0) begin
                        level_nxt = '0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        level_nxt = rel_diff[ENV_W-1:0];
                    end
                end
                default: begin
                    level_nxt = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            env_level <= '0;
            env_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            env_level <= level_nxt;
            env_done  <= done_nxt;
        end
    end

    assign env_state  = state;
    assign env_active = (state != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: vector table of per-cycle controls and expected
// outputs, routed through an expected-value queue, plus a hand-written async reset case.
module tb_adsr_envelope;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        trigger, gate, sample_tick;
    logic [15:0] attack_rate, decay_rate, release_rate, sustain_level;
    logic [15:0] env_level;
    logic        env_active, env_done;
    logic [2:0]  env_state;

    adsr_envelope #(.ENV_W(16), .RATE_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .trigger(trigger), .gate(gate),
        .sample_tick(sample_tick), .attack_rate(attack_rate),
        .decay_rate(decay_rate), .sustain_level(sustain_level),
        .release_rate(release_rate), .env_level(env_level),
        .env_active(env_active), .env_done(env_done), .env_state(env_state)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          trig, gt, tck;
        logic [15:0] ar, dr, sl, rr;
        logic [15:0] lvl;
        logic [2:0]  st;
        bit          done;
    } vec_t;

    vec_t        tbl[$];
    vec_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] c_ar, c_dr, c_sl, c_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input bit trig, input bit gt, input bit tck,
                                input logic [15:0] lvl, input logic [2:0] st, input bit done);
        vec_t v;
        v.trig = trig; v.gt = gt; v.tck = tck;
        v.ar = c_ar; v.dr = c_dr; v.sl = c_sl; v.rr = c_rr;
        v.lvl = lvl; v.st = st; v.done = done;
        tbl.push_back(v);
    endfunction

    task automatic run_table(input string tag);
        vec_t v, e;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge Clk);
            trigger = v.trig; gate = v.gt; sample_tick = v.tck;
            attack_rate = v.ar; decay_rate = v.dr; sustain_level = v.sl; release_rate = v.rr;
            sb.push_back(v);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d].level", tag, i), 32'(env_level), 32'(e.lvl));
            check($sformatf("%s[%0d].state", tag, i), 32'(env_state), 32'(e.st));
            check($sformatf("%s[%0d].active", tag, i), 32'(env_active), 32'(e.st != 3'd0));
            check($sformatf("%s[%0d].done", tag, i), 32'(env_done), 32'(e.done));
        end
        tbl.delete();
    endtask

    initial begin
        Reset = 1'b1; trigger = 0; gate = 0; sample_tick = 0;
        attack_rate = 0; decay_rate = 0; sustain_level = 0; release_rate = 0;
        #12;
        check("reset.level", 32'(env_level), 0);
        check("reset.state", 32'(env_state), 0);
        check("reset.active", 32'(env_active), 0);
        check("reset.done", 32'(env_done), 0);
        @(negedge Clk); Reset = 1'b0;

        // Full cycle; first vector is trigger coincident with a tick in IDLE.
        c_ar = 16384; c_dr = 8192; c_sl = 40000; c_rr = 10000;
        add(1,1,1, 0,1,0);     add(0,1,0, 0,1,0);
        add(0,1,1, 16384,1,0); add(0,1,1, 32768,1,0); add(0,1,1, 49152,1,0);
        add(0,1,1, 65535,2,0); add(0,1,1, 57343,2,0); add(0,1,1, 49151,2,0);
        add(0,1,1, 40959,2,0); add(0,1,1, 40000,3,0); add(0,1,0, 40000,3,0);
        add(0,0,1, 40000,4,0); add(0,0,1, 30000,4,0); add(0,0,1, 20000,4,0);
        add(0,0,1, 10000,4,0); add(0,0,1, 0,0,1);     add(0,0,0, 0,0,0);
        run_table("full");

        // Retrigger during RELEASE at 20000 ramps from there with no dip.
        c_ar = 0;
        add(1,1,0, 0,1,0);     add(0,1,1, 65535,2,0); add(0,1,1, 57343,2,0);
        add(0,1,1, 49151,2,0); add(0,1,1, 40959,2,0); add(0,1,1, 40000,3,0);
        add(0,0,0, 40000,4,0); add(0,0,1, 30000,4,0); add(0,0,1, 20000,4,0);
        c_ar = 16384;
        add(1,1,1, 20000,1,0); add(0,1,1, 36384,1,0); add(0,1,1, 52768,1,0);
        add(0,1,1, 65535,2,0);
        add(0,0,0, 65535,4,0); add(0,0,1, 55535,4,0);
        run_table("retrig");

        // Zero rates jump straight to each target.
        c_ar = 0; c_dr = 0; c_rr = 0; c_sl = 1000;
        add(1,1,0, 55535,1,0); add(0,1,1, 65535,2,0); add(0,1,1, 1000,3,0);
        add(0,0,0, 1000,4,0);  add(0,0,1, 0,0,1);     add(0,0,0, 0,0,0);
        run_table("zero");

        // Early release from ATTACK at 32768.
        c_ar = 16384; c_dr = 8192; c_sl = 40000; c_rr = 10000;
        add(1,1,0, 0,1,0);     add(0,1,1, 16384,1,0); add(0,1,1, 32768,1,0);
        add(0,0,1, 32768,4,0); add(0,0,1, 22768,4,0); add(0,0,1, 12768,4,0);
        add(0,0,1, 2768,4,0);  add(0,0,1, 0,0,1);     add(0,0,1, 0,0,0);
        // Trigger glitch with gate low: ATTACK then immediate RELEASE.
        add(1,0,0, 0,1,0);     add(0,0,0, 0,4,0);     add(0,0,1, 0,0,1);
        run_table("early");

        // Sustain at full scale, then at zero with a live sustain change.
        c_ar = 0; c_sl = 16'hFFFF;
        add(1,1,0, 0,1,0);     add(0,1,1, 65535,2,0); add(0,1,1, 65535,3,0);
        c_sl = 0; c_dr = 0;
        add(0,1,1, 0,3,0);
        c_sl = 0; c_dr = 8192;
        add(1,1,0, 0,1,0);     add(0,1,1, 65535,2,0);
        c_dr = 0;
        add(0,1,1, 0,3,0);     add(0,1,1, 0,3,0);
        c_sl = 500;
        add(0,1,0, 0,3,0);     add(0,1,1, 500,3,0);
        c_sl = 0;
        add(0,1,1, 0,3,0);     add(0,0,0, 0,4,0);     add(0,0,1, 0,0,1);
        run_table("edge");

        // Async reset mid-DECAY, between clock edges.
        c_ar = 0; c_dr = 8192; c_sl = 40000;
        add(1,1,0, 0,1,0); add(0,1,1, 65535,2,0); add(0,1,1, 57343,2,0);
        run_table("pre_rst");
        #2 Reset = 1'b1;
        #1;
        check("async_rst.level", 32'(env_level), 0);
        check("async_rst.state", 32'(env_state), 0);
        check("async_rst.active", 32'(env_active), 0);
        check("async_rst.done", 32'(env_done), 0);
        @(negedge Clk); Reset = 1'b0;
        add(0,1,1, 0,0,0); add(0,1,1, 0,0,0); add(0,1,0, 0,0,0);
        add(1,1,1, 0,1,0); add(0,1,1, 65535,2,0);
        run_table("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
